// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types and default sizing for the memory refill arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 26;
  localparam int unsigned ARB_DATA_WIDTH = 32;
  localparam int unsigned ARB_BURST_LEN  = 4;
  localparam int unsigned STAT_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_e;

  // A single-beat burst still needs a 1-bit counter.
  function automatic int unsigned beat_cnt_width(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// External memory port: command, write-beat and read-beat channels.
interface mem_refill_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_wvalid;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    input  mem_gnt, mem_wready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata,
    output mem_gnt, mem_wready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_refill_arbiter_beat_counter.sv
// Beat counter for one burst: counts handshakes, flags the last beat, wraps to 0 after it.
module arb_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = ARB_BURST_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clear,
  output logic last
);

  localparam int unsigned CNT_W = beat_cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin owner of the external memory port for I-cache refills and D-cache refills/writebacks.
// Optional MEM_ARB_STATS_EN builds saturating per-requester wait-cycle counters.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = ARB_BURST_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_req,
  input  logic [ADDR_WIDTH-1:0]   ic_addr,
  output logic                    ic_rvalid,
  output logic [DATA_WIDTH-1:0]   ic_rdata,
  output logic                    ic_done,
  input  logic                    dc_req,
  input  logic                    dc_we,
  input  logic [ADDR_WIDTH-1:0]   dc_addr,
  input  logic [DATA_WIDTH-1:0]   dc_wdata,
  output logic                    dc_wready,
  output logic                    dc_rvalid,
  output logic [DATA_WIDTH-1:0]   dc_rdata,
  output logic                    dc_done,
  mem_refill_arbiter_if.master    mem,
  output logic                    busy,
  output logic [STAT_WIDTH-1:0]   stat_ic_wait,
  output logic [STAT_WIDTH-1:0]   stat_dc_wait
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  arb_owner_e            last_owner_q, last_owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic in_data;
  logic beat_fire;
  logic beat_last;
  logic rd_beat;

  assign in_data   = (state_q == DATA);
  assign beat_fire = in_data & (we_q ? mem.mem_wready : mem.mem_rvalid);
  assign rd_beat   = in_data & ~we_q & mem.mem_rvalid;

  arb_beat_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (beat_fire),
    .clear (~in_data),
    .last  (beat_last)
  );

  // Next state and pick: on a tie the port goes to whoever did not have it last.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    unique case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          if (ic_req && (!dc_req || last_owner_q == OWN_DC)) begin
            owner_d = OWN_IC;
            we_d    = 1'b0;
            addr_d  = ic_addr;
          end else begin
            owner_d = OWN_DC;
            we_d    = dc_we;
            addr_d  = dc_addr;
          end
          last_owner_d = owner_d;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (mem.mem_gnt) state_d = DATA;
      end
      DATA: begin
        if (beat_fire && beat_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_DC;
      we_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign mem.mem_req     = (state_q == CMD);
  assign mem.mem_we      = busy & we_q;
  assign mem.mem_addr    = (state_q == CMD) ? addr_q : '0;
  assign mem.mem_wvalid  = in_data & we_q;
  assign mem.mem_wdata   = mem.mem_wvalid ? dc_wdata : '0;

  // Read data is shared; only the owner's valid qualifies it.
  assign ic_rvalid = rd_beat & (owner_q == OWN_IC);
  assign dc_rvalid = rd_beat & (owner_q == OWN_DC);
  assign ic_rdata  = rd_beat ? mem.mem_rdata : '0;
  assign dc_rdata  = rd_beat ? mem.mem_rdata : '0;
  assign dc_wready = mem.mem_wvalid & mem.mem_wready;
  assign ic_done   = beat_fire & beat_last & (owner_q == OWN_IC);
  assign dc_done   = beat_fire & beat_last & (owner_q == OWN_DC);

`ifdef MEM_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] ic_wait_q, ic_wait_d;
  logic [STAT_WIDTH-1:0] dc_wait_q, dc_wait_d;
  logic                  ic_held, dc_held;

  // Count cycles a request is pending while the port is not held for it.
  always_comb begin
    ic_held   = busy && (owner_q == OWN_IC);
    dc_held   = busy && (owner_q == OWN_DC);
    ic_wait_d = ic_wait_q;
    dc_wait_d = dc_wait_q;
    if (ic_req && !ic_held && (ic_wait_q != '1)) ic_wait_d = ic_wait_q + STAT_WIDTH'(1);
    if (dc_req && !dc_held && (dc_wait_q != '1)) dc_wait_d = dc_wait_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_wait_q <= '0;
      dc_wait_q <= '0;
    end else begin
      ic_wait_q <= ic_wait_d;
      dc_wait_q <= dc_wait_d;
    end
  end

  assign stat_ic_wait = ic_wait_q;
  assign stat_dc_wait = dc_wait_q;
`else
  assign stat_ic_wait = '0;
  assign stat_dc_wait = '0;
`endif

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: burst table, directed corner sequences, random traffic vs. model.
module tb_mem_refill_arbiter;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int BL = 4;

  logic          clk;
  logic          rst_n;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_rvalid;
  logic [DW-1:0] ic_rdata;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_wready;
  logic          dc_rvalid;
  logic [DW-1:0] dc_rdata;
  logic          dc_done;
  logic          busy;
  logic [31:0]   stat_ic_wait;
  logic [31:0]   stat_dc_wait;

  int n_checks = 0;
  int n_errors = 0;

  mem_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_req       (ic_req),
    .ic_addr      (ic_addr),
    .ic_rvalid    (ic_rvalid),
    .ic_rdata     (ic_rdata),
    .ic_done      (ic_done),
    .dc_req       (dc_req),
    .dc_we        (dc_we),
    .dc_addr      (dc_addr),
    .dc_wdata     (dc_wdata),
    .dc_wready    (dc_wready),
    .dc_rvalid    (dc_rvalid),
    .dc_rdata     (dc_rdata),
    .dc_done      (dc_done),
    .mem          (mem_if),
    .busy         (busy),
    .stat_ic_wait (stat_ic_wait),
    .stat_dc_wait (stat_dc_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ic;
    logic          dc;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic          we;
    int            gnt_wait;
    bit            wr_alt;
    int            exp_owner;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    mem_if.mem_gnt = 0; mem_if.mem_wready = 0; mem_if.mem_rvalid = 0; mem_if.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one burst as cache + memory agents; reports what the DUT did.
  task automatic run_burst(
    input  logic ic, input logic dc, input logic [AW-1:0] ia, input logic [AW-1:0] da,
    input  logic we, input int gnt_wait, input bit wr_alt, input int drop_after,
    output int owner, output logic [AW-1:0] c_addr, output logic c_we, output int req_lat,
    output int rv_ic, output int rv_dc, output int wr_dc,
    output int dones_ic, output int dones_dc, output bit timeout);
    int cmd_cyc;
    bit fin;
    bit adv;
    owner = -1; c_addr = '0; c_we = 0; req_lat = -1;
    rv_ic = 0; rv_dc = 0; wr_dc = 0; dones_ic = 0; dones_dc = 0;
    cmd_cyc = 0; fin = 0;
    ic_req = ic; dc_req = dc; ic_addr = ia; dc_addr = da; dc_we = we;
    dc_wdata = 32'h5000_0000;
    for (int c = 0; c < 80 && !fin; c++) begin
      adv = 0;
      mem_if.mem_gnt = 0; mem_if.mem_rvalid = 0; mem_if.mem_wready = 0;
      mem_if.mem_rdata = DW'(32'hA + 32'(rv_ic + rv_dc));
      if (mem_if.mem_req) begin
        if (req_lat < 0) begin
          req_lat = c; c_addr = mem_if.mem_addr; c_we = mem_if.mem_we;
        end
        mem_if.mem_gnt = (cmd_cyc == gnt_wait);
        cmd_cyc++;
      end else if (busy) begin
        mem_if.mem_rvalid = 1;
        mem_if.mem_wready = wr_alt ? (c % 2 == 0) : 1'b1;
      end
      #1;
      if (ic_rvalid) begin
        chk("ic_rdata", ic_rdata, 64'(32'hA + 32'(rv_ic)));
        rv_ic++;
      end
      if (dc_rvalid) begin
        chk("dc_rdata", dc_rdata, 64'(32'hA + 32'(rv_dc)));
        rv_dc++;
      end
      if (mem_if.mem_wvalid) chk("mem_wdata", mem_if.mem_wdata, dc_wdata);
      if (dc_wready) begin
        wr_dc++;
        adv = 1;
      end
      if (ic_done) begin dones_ic++; owner = 0; fin = 1; end
      if (dc_done) begin dones_dc++; owner = 1; fin = 1; end
      if (fin) chk("done_on_last_beat", rv_ic + rv_dc + wr_dc, BL);
      if (drop_after >= 0 && (rv_ic + rv_dc + wr_dc) >= drop_after) begin
        ic_req = 0; dc_req = 0;
      end
      tick();
      if (adv) dc_wdata = dc_wdata + 32'h11;
    end
    ic_req = 0; dc_req = 0;
    mem_if.mem_rvalid = 0; mem_if.mem_wready = 0; mem_if.mem_gnt = 0;
    timeout = !fin;
  endtask

  // Random traffic compared cycle by cycle against a burst-level model.
  task automatic random_test(input int ncyc);
    int m_phase, m_owner, m_last, m_beats;
    logic m_we;
    logic [AW-1:0] m_addr;
    bit p_ic_done, p_dc_done;
    logic [31:0] e_icw, e_dcw;
    bit e_busy, e_req, e_data, e_beat, e_last, e_icrv, e_dcrv;
    do_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_beats = 0; m_we = 0; m_addr = '0;
    p_ic_done = 0; p_dc_done = 0; e_icw = 0; e_dcw = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (p_ic_done || !ic_req) begin
        ic_req = ($urandom_range(0, 3) == 0);
        ic_addr = AW'($urandom);
      end
      if (p_dc_done || !dc_req) begin
        dc_req = ($urandom_range(0, 3) == 0);
        dc_addr = AW'($urandom);
        dc_we = $urandom_range(0, 1) == 1;
      end
      dc_wdata = $urandom;
      mem_if.mem_gnt = ($urandom_range(0, 2) == 0);
      mem_if.mem_rvalid = $urandom_range(0, 1) == 1;
      mem_if.mem_wready = $urandom_range(0, 1) == 1;
      mem_if.mem_rdata = $urandom;
      #1;
      e_busy = (m_phase != 0);
      e_req  = (m_phase == 1);
      e_data = (m_phase == 2);
      e_beat = e_data && (m_we ? mem_if.mem_wready : mem_if.mem_rvalid);
      e_last = e_beat && (m_beats == BL - 1);
      e_icrv = e_data && !m_we && m_owner == 0 && mem_if.mem_rvalid;
      e_dcrv = e_data && !m_we && m_owner == 1 && mem_if.mem_rvalid;
      chk("rnd_busy", busy, e_busy);
      chk("rnd_mem_req", mem_if.mem_req, e_req);
      if (e_req) begin
        chk("rnd_mem_addr", mem_if.mem_addr, m_addr);
        chk("rnd_mem_we", mem_if.mem_we, m_we);
      end
      chk("rnd_mem_wvalid", mem_if.mem_wvalid, e_data && m_we);
      chk("rnd_ic_rvalid", ic_rvalid, e_icrv);
      chk("rnd_dc_rvalid", dc_rvalid, e_dcrv);
      chk("rnd_dc_wready", dc_wready, e_data && m_we && mem_if.mem_wready);
      chk("rnd_ic_done", ic_done, e_last && m_owner == 0);
      chk("rnd_dc_done", dc_done, e_last && m_owner == 1);
      if (e_icrv) chk("rnd_ic_rdata", ic_rdata, mem_if.mem_rdata);
      if (e_dcrv) chk("rnd_dc_rdata", dc_rdata, mem_if.mem_rdata);
      if (e_data && m_we) chk("rnd_mem_wdata", mem_if.mem_wdata, dc_wdata);
`ifdef MEM_ARB_STATS_EN
      chk("rnd_stat_ic", stat_ic_wait, e_icw);
      chk("rnd_stat_dc", stat_dc_wait, e_dcw);
`else
      chk("rnd_stat_ic", stat_ic_wait, 0);
      chk("rnd_stat_dc", stat_dc_wait, 0);
`endif
      p_ic_done = e_last && m_owner == 0;
      p_dc_done = e_last && m_owner == 1;
      if (ic_req && !(e_busy && m_owner == 0) && e_icw != 32'hFFFF_FFFF) e_icw++;
      if (dc_req && !(e_busy && m_owner == 1) && e_dcw != 32'hFFFF_FFFF) e_dcw++;
      if (m_phase == 0) begin
        if (ic_req || dc_req) begin
          m_owner = (ic_req && dc_req) ? 1 - m_last : (ic_req ? 0 : 1);
          m_last  = m_owner;
          m_we    = (m_owner == 1) ? dc_we : 1'b0;
          m_addr  = (m_owner == 1) ? dc_addr : ic_addr;
          m_beats = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_if.mem_gnt) m_phase = 2;
      end else if (e_beat) begin
        m_beats++;
        if (m_beats == BL) m_phase = 0;
      end
      tick();
    end
    zero_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int owner, req_lat, rv_ic, rv_dc, wr_dc, d_ic, d_dc, cnt, last_done;
    logic [AW-1:0] c_addr;
    logic c_we;
    bit to, prev_req;
    int order[$];

    vecs[0] = '{1'b1, 1'b0, 26'h12, 26'h00, 1'b0, 1, 1'b0, 0, 26'h12, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 26'h20, 26'h30, 1'b0, 0, 1'b0, 1, 26'h30, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 26'h21, 26'h31, 1'b0, 2, 1'b0, 0, 26'h21, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 26'h00, 26'h3F, 1'b1, 0, 1'b1, 1, 26'h3F, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 26'h00, 26'h05, 1'b0, 1, 1'b0, 1, 26'h05, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 26'h22, 26'h06, 1'b1, 0, 1'b1, 0, 26'h22, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 26'h23, 26'h00, 1'b0, 3, 1'b0, 0, 26'h23, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 26'h24, 26'h07, 1'b1, 0, 1'b1, 1, 26'h07, 1'b1};

    // Reset state, with stray memory activity present.
    rst_n = 1'b0;
    zero_inputs();
    mem_if.mem_rvalid = 1; mem_if.mem_wready = 1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_mem_we", mem_if.mem_we, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    chk("rst_mem_wvalid", mem_if.mem_wvalid, 0);
    chk("rst_ic_rvalid", ic_rvalid, 0);
    chk("rst_dc_rvalid", dc_rvalid, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_wready", dc_wready, 0);
    chk("rst_dones", {ic_done, dc_done}, 0);
    chk("rst_stats", {stat_ic_wait, stat_dc_wait}, 0);
    do_reset();

    // Burst table: arbitration history carries from one entry to the next.
    foreach (vecs[i]) begin
      run_burst(vecs[i].ic, vecs[i].dc, vecs[i].ia, vecs[i].da, vecs[i].we, vecs[i].gnt_wait,
                vecs[i].wr_alt, -1, owner, c_addr, c_we, req_lat, rv_ic, rv_dc, wr_dc, d_ic, d_dc, to);
      chk($sformatf("vec%0d_timeout", i), to, 0);
      chk($sformatf("vec%0d_owner", i), owner, vecs[i].exp_owner);
      chk($sformatf("vec%0d_addr", i), c_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_we", i), c_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_req_latency", i), req_lat, 1);
      chk($sformatf("vec%0d_ic_rvalid_beats", i), rv_ic, (vecs[i].exp_owner == 0) ? BL : 0);
      chk($sformatf("vec%0d_dc_rvalid_beats", i), rv_dc,
          (vecs[i].exp_owner == 1 && !vecs[i].exp_we) ? BL : 0);
      chk($sformatf("vec%0d_dc_wready_beats", i), wr_dc, vecs[i].exp_we ? BL : 0);
      chk($sformatf("vec%0d_ic_done", i), d_ic, (vecs[i].exp_owner == 0) ? 1 : 0);
      chk($sformatf("vec%0d_dc_done", i), d_dc, (vecs[i].exp_owner == 1) ? 1 : 0);
    end

    // Both requests held: alternating grants, one bubble between bursts.
    do_reset();
    ic_req = 1; dc_req = 1; ic_addr = 26'h100; dc_addr = 26'h200; dc_we = 0;
    last_done = -1; prev_req = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      mem_if.mem_gnt = mem_if.mem_req;
      mem_if.mem_rvalid = busy && !mem_if.mem_req;
      mem_if.mem_rdata = $urandom;
      #1;
      if (mem_if.mem_req && !prev_req && last_done >= 0) chk("rr_bubble_gap", c - last_done, 2);
      prev_req = mem_if.mem_req;
      if (ic_done) begin order.push_back(0); last_done = c; end
      if (dc_done) begin order.push_back(1); last_done = c; end
      tick();
    end
    chk("rr_burst_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk($sformatf("rr_order%0d", i), order[i], i % 2);

    // Reset after two beats of an I-cache refill, then a clean refill.
    do_reset();
    ic_req = 1; ic_addr = 26'h40; cnt = 0;
    for (int c = 0; c < 40 && cnt < 2; c++) begin
      mem_if.mem_gnt = mem_if.mem_req;
      mem_if.mem_rvalid = busy && !mem_if.mem_req;
      #1;
      if (ic_rvalid) cnt++;
      tick();
    end
    chk("midrst_beats_before", cnt, 2);
    mem_if.mem_rvalid = 1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_req", mem_if.mem_req, 0);
    chk("midrst_ic_rvalid", ic_rvalid, 0);
    chk("midrst_ic_done", ic_done, 0);
    ic_req = 0; mem_if.mem_rvalid = 0; mem_if.mem_gnt = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_burst(1'b1, 1'b0, 26'h41, 26'h0, 1'b0, 0, 1'b0, -1,
              owner, c_addr, c_we, req_lat, rv_ic, rv_dc, wr_dc, d_ic, d_dc, to);
    chk("postrst_timeout", to, 0);
    chk("postrst_owner", owner, 0);
    chk("postrst_addr", c_addr, 26'h41);
    chk("postrst_ic_beats", rv_ic, BL);
    chk("postrst_ic_done", d_ic, 1);

    // Stray beats in IDLE, then a D-cache refill whose request drops after beat 1.
    do_reset();
    mem_if.mem_rvalid = 1; mem_if.mem_wready = 1; mem_if.mem_gnt = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stray_ic_rvalid", ic_rvalid, 0);
      chk("stray_dc_rvalid", dc_rvalid, 0);
      chk("stray_dc_wready", dc_wready, 0);
      chk("stray_busy", busy, 0);
      tick();
    end
    run_burst(1'b0, 1'b1, 26'h0, 26'h77, 1'b0, 0, 1'b0, 1,
              owner, c_addr, c_we, req_lat, rv_ic, rv_dc, wr_dc, d_ic, d_dc, to);
    chk("drop_timeout", to, 0);
    chk("drop_owner", owner, 1);
    chk("drop_dc_beats", rv_dc, BL);
    chk("drop_dc_done", d_dc, 1);
    chk("drop_ic_beats", rv_ic, 0);

    // D-cache waits 7 cycles behind an I-cache command that is never granted.
    do_reset();
    ic_req = 1; ic_addr = 26'h9;
    tick();
    dc_req = 1; dc_addr = 26'hA;
    repeat (7) tick();
`ifdef MEM_ARB_STATS_EN
    chk("stat_dc_wait", stat_dc_wait, 7);
    chk("stat_ic_wait", stat_ic_wait, 1);
`else
    chk("stat_dc_wait", stat_dc_wait, 0);
    chk("stat_ic_wait", stat_ic_wait, 0);
`endif
    zero_inputs();

    random_test(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
